row_buff_sched: RTL and testbench
=================================

Name: row_buff_sched

Overview:
Sequencer for a bank of NUM_ROWS ROW_BUFF line buffers in the streaming filter pipeline.
- Accepts pixel beats from the upstream stream.
- Drives write_enable/read_enable of each row buffer, rotating the write target once per row.
- Registers the current beat alongside the row-buffer outputs.
- Emits a vertical-window valid with the buffer index of the oldest row, so downstream can assemble an NUM_ROWS-tall column of beats.

Parameters:
PIXELS_PER_BEAT, 16, pixels per beat.
IMAGE_DIM, 512, pixels per row and rows per frame (square image).
NUM_ROWS, 3, window height = number of row buffers; must be >= 2.
DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width in bits.
Derived localparam BEATS_PER_ROW = IMAGE_DIM/PIXELS_PER_BEAT; it equals the ROW_BUFF depth.

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous, active-low; shared with all ROW_BUFF instances
s_valid  in  1  upstream beat valid
s_ready  out  1  upstream ready
s_sof  in  1  start-of-frame marker, qualified by accept
s_data  in  DATA_WIDTH  upstream beat; wired to every ROW_BUFF inp_frame
buf_wr_en  out  NUM_ROWS  one-hot write_enable per row buffer
buf_rd_en  out  NUM_ROWS  read_enable per row buffer
m_valid  out  1  window valid
m_ready  in  1  downstream ready
m_cur  out  DATA_WIDTH  registered current-row beat
m_row_base  out  $clog2(NUM_ROWS)  buffer index holding the oldest row of the window
m_col  out  $clog2(BEATS_PER_ROW)  beat column of the window
frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted
sof_err  out  1  sticky: s_sof seen at a non-origin position

Behaviour:
- accept = s_valid && s_ready.
- s_ready = (state != DONE) && (!m_valid || m_ready). The single output stage gives no skid.
- On accept, all three happen in the same cycle:
  - buf_wr_en = onehot(wr_sel).
  - buf_rd_en = all ones.
  - m_cur <= s_data.
- All buffers are read on every accept, so ROW_BUFF read/write pointers advance exactly BEATS_PER_ROW per row and stay aligned modulo depth. No pointer control is needed.
- When there is no accept, buf_wr_en and buf_rd_en are 0, so ROW_BUFF out_frame holds during stalls.
- Counters: col_cnt 0..BEATS_PER_ROW-1; row_cnt 0..IMAGE_DIM-1; wr_sel 0..NUM_ROWS-1.
  - col_cnt wraps at end of row; row_cnt and wr_sel increment at that point.
  - wr_sel wraps NUM_ROWS-1 -> 0.
- States:
  - IDLE -> FILL on first accept.
  - FILL -> STREAM on accept of beat (row NUM_ROWS-1, col 0).
  - STREAM -> DONE on accept of last beat (row IMAGE_DIM-1, col BEATS_PER_ROW-1).
  - DONE -> IDLE next cycle. In DONE: frame_done=1, all counters cleared, wr_sel=0.
- Output stage, one-cycle latency from accept:
  - m_valid is set on an accept where the pre-increment row_cnt >= NUM_ROWS-1; otherwise it is cleared when m_ready.
  - On such an accept, m_row_base <= (wr_sel+1) mod NUM_ROWS and m_col <= col_cnt.
  - The valid window is: buffers other than wr_sel, ordered oldest-first from m_row_base, then m_cur.
  - Data read from buffer wr_sel at that beat is stale and is ignored downstream.
- FILL rows produce no m_valid.
- s_sof handling:
  - s_sof on accept at row0/col0 is normal.
  - Elsewhere: sof_err <= 1 (sticky until reset); the beat is treated as row0/col0; state -> FILL; wr_sel <= 0.
  - Row buffer pointers remain aligned only if the aborted row was complete. This is a documented limitation.
- Reset, including mid-frame: state IDLE; all counters 0; m_valid 0; m_cur 0; m_row_base 0; m_col 0; buf_wr_en 0; buf_rd_en 0; frame_done 0; sof_err 0. ROW_BUFF instances reset on the same aresetn, so pointers realign.

Optional Feature:
ROW_BUFF_SCHED_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0], counting cycles with s_valid && !s_ready.
  - Saturates at all ones.
  - Cleared on reset and on the cycle of a frame's first accept.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
1. Reset held 3 cycles with s_valid=1 -> all outputs 0; s_ready=1 after release; no buf_wr_en/buf_rd_en activity during reset.
2. IMAGE_DIM=64, PPB=16, NUM_ROWS=3, continuous stream, m_ready=1:
   - buf_wr_en sequence 001x4, 010x4, 100x4, 001x4, ...
   - First m_valid one cycle after accepting beat 8 (row2 col0), with m_row_base=0 and m_col=0.
   - m_valid count per frame = 62*4 = 248.
   - frame_done pulses one cycle after beat 256, with s_ready=0 that cycle.
3. Backpressure: m_ready=0 for 5 cycles mid-STREAM -> s_ready=0, buf enables 0, m_cur/m_col/m_row_base stable; resumes with no lost or duplicated beat (checked against a reference model of row data).
4. Misaligned sof: s_sof=1 at row5 col2 -> sof_err=1 and stays set; next m_valid only after 2 further full rows; wr_en restarts at 001.
5. aresetn low mid-row (row10 col1) for 1 cycle, then a full frame -> identical output to a clean-start frame.
6. With ROW_BUFF_SCHED_STALL_CNT_EN: 7 stalled cycles with s_valid=1 -> stall_cnt=7; clears to 0 at the next frame's first accept.

Source files
------------

// File: rtl/row_buff_sched.sv
// Write/read sequencer for a bank of NUM_ROWS row buffers. It also builds the vertical window.
// Optional: define ROW_BUFF_SCHED_STALL_CNT_EN to add the stall_cnt output.
module row_buff_sched #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int NUM_ROWS        = 3,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                                          clk,
    input  logic                                          aresetn,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic                                          s_sof,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    output logic [NUM_ROWS-1:0]                           buf_wr_en,
    output logic [NUM_ROWS-1:0]                           buf_rd_en,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_WIDTH-1:0]                         m_cur,
    output logic [$clog2(NUM_ROWS)-1:0]                   m_row_base,
    output logic [$clog2(IMAGE_DIM/PIXELS_PER_BEAT)-1:0]  m_col,
    output logic                                          frame_done,
    output logic                                          sof_err
`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                                   stall_cnt
`endif
);

    localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int SEL_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(BEATS_PER_ROW);
    localparam int ROW_W = $clog2(IMAGE_DIM);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_FILL = ROW_W'(NUM_ROWS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;

    logic               accept;
    logic               sof_mis;
    logic [COL_W-1:0]   eff_col;
    logic [ROW_W-1:0]   eff_row;
    logic [SEL_W-1:0]   eff_sel;
    logic               row_end;
    logic               last_beat;
    logic               win_beat;

    assign s_ready = aresetn && (state_reg != DONE) && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;

    // A misplaced start-of-frame restarts the frame: this beat becomes row 0 / col 0 in buffer 0.
    assign sof_mis   = accept && s_sof && ((col_reg != '0) || (row_reg != '0));
    assign eff_col   = sof_mis ? '0 : col_reg;
    assign eff_row   = sof_mis ? '0 : row_reg;
    assign eff_sel   = sof_mis ? '0 : sel_reg;
    assign row_end   = (eff_col == COL_LAST);
    assign last_beat = row_end && (eff_row == ROW_LAST);
    assign win_beat  = accept && (eff_row >= ROW_FILL);

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = FILL;
            FILL:    if (accept && (eff_row == ROW_FILL) && (eff_col == '0)) state_next = STREAM;
            STREAM: begin
                if (sof_mis)
                    state_next = FILL;
                else if (accept && last_beat)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state_reg == DONE);
        buf_rd_en  = accept ? '1 : '0;
    end

    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_wr_en
            assign buf_wr_en[gi] = accept && (eff_sel == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        sel_next = sel_reg;
        if (state_reg == DONE) begin
            col_next = '0;
            row_next = '0;
            sel_next = '0;
        end else if (accept) begin
            col_next = eff_col;
            row_next = eff_row;
            sel_next = eff_sel;
            if (row_end) begin
                col_next = '0;
                row_next = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
                sel_next = (eff_sel == SEL_LAST) ? '0 : eff_sel + SEL_W'(1);
            end else begin
                col_next = eff_col + COL_W'(1);
            end
        end
    end

    // Window output stage: the oldest row lives in the buffer after the one now being written.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_valid    <= 1'b0;
            m_cur      <= '0;
            m_row_base <= '0;
            m_col      <= '0;
            sof_err    <= 1'b0;
        end else begin
            if (accept)
                m_cur <= s_data;
            if (win_beat) begin
                m_valid    <= 1'b1;
                m_row_base <= (eff_sel == SEL_LAST) ? '0 : eff_sel + SEL_W'(1);
                m_col      <= eff_col;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (sof_mis)
                sof_err <= 1'b1;
        end
    end

`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!aresetn)
            stall_cnt <= '0;
        else if (accept && (state_reg == IDLE))
            stall_cnt <= '0;
        else if (s_valid && !s_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_row_buff_sched.sv
// Directed bench for row_buff_sched: 64x64 image, 16 pixels per beat, 3 rows.
module tb_row_buff_sched;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         s_valid;
    logic         s_ready;
    logic         s_sof;
    logic [127:0] s_data;
    logic [2:0]   buf_wr_en;
    logic [2:0]   buf_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_cur;
    logic [1:0]   m_row_base;
    logic [1:0]   m_col;
    logic         frame_done;
    logic         sof_err;
`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    row_buff_sched #(
        .PIXELS_PER_BEAT(16),
        .IMAGE_DIM      (64),
        .NUM_ROWS       (3)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_data    (s_data),
        .buf_wr_en (buf_wr_en),
        .buf_rd_en (buf_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_cur     (m_cur),
        .m_row_base(m_row_base),
        .m_col     (m_col),
        .frame_done(frame_done),
        .sof_err   (sof_err)
`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [127:0] mk(input int f, input int k);
        logic [31:0] w;
        w = 32'(f * 65536 + k);
        return {w, w, w, w};
    endfunction

    // Presents one beat, waits (bounded) for s_ready, records the enables and clocks it in.
    task automatic drive_beat(input logic [127:0] d, input logic sof,
                              output logic [2:0] wr, output logic [2:0] rd, output logic to);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        to      = 1'b0;
        n       = 0;
        #1;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready)
            to = 1'b1;
        wr = buf_wr_en;
        rd = buf_rd_en;
        @(posedge clk);
        #1;
        s_sof = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_valid = 1'b1;
        s_data  = mk(9, 9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({buf_wr_en, buf_rd_en} !== 6'b0) begin
                errors++;
                $display("FAIL reset_en cycle %0d: wr=%b rd=%b expected 000/000", i, buf_wr_en, buf_rd_en);
            end
            checks++;
            if ({s_ready, m_valid, frame_done, sof_err, m_row_base, m_col} !== 8'b0 || m_cur !== 128'b0) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: ready=%b valid=%b done=%b err=%b base=%0d col=%0d cur=%h expected all 0",
                         i, s_ready, m_valid, frame_done, sof_err, m_row_base, m_col, m_cur);
            end
        end
        aresetn = 1'b1;
        s_valid = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: s_ready=%b expected 1", s_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [2:0] wr, rd;
        logic       to;
        int         vcnt = 0;
        for (int k = 0; k < 256; k++) begin
            int row = k / 4;
            int col = k % 4;
            drive_beat(mk(1, k), k == 0, wr, rd, to);
            checks++;
            if (to !== 1'b0) begin
                errors++;
                $display("FAIL stream_timeout beat %0d: s_ready stuck 0, expected 1", k);
            end
            checks++;
            if (wr !== (3'b001 << (row % 3)) || rd !== 3'b111) begin
                errors++;
                $display("FAIL stream_en beat %0d: wr=%b rd=%b expected %b/111", k, wr, rd, 3'b001 << (row % 3));
            end
            checks++;
            if (m_valid !== (row >= 2)) begin
                errors++;
                $display("FAIL stream_valid beat %0d: m_valid=%b expected %b", k, m_valid, row >= 2);
            end
            if (row >= 2) begin
                vcnt++;
                checks++;
                if ({m_row_base, m_col} !== {2'((row % 3 + 1) % 3), 2'(col)} || m_cur !== mk(1, k)) begin
                    errors++;
                    $display("FAIL stream_window beat %0d: base=%0d col=%0d cur=%h expected %0d/%0d/%h",
                             k, m_row_base, m_col, m_cur, (row % 3 + 1) % 3, col, mk(1, k));
                end
            end
        end
        checks++;
        if (vcnt != 248) begin
            errors++;
            $display("FAIL stream_vcount: %0d windows, expected 248", vcnt);
        end
        checks++;
        if (frame_done !== 1'b1 || s_ready !== 1'b0 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL stream_done: done=%b ready=%b wr=%b expected 1/0/000", frame_done, s_ready, buf_wr_en);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: done=%b ready=%b valid=%b expected 0/1/0", frame_done, s_ready, m_valid);
        end
        $display("test_stream done, windows=%0d", vcnt);
    endtask

    task automatic test_backpressure();
        logic [2:0] wr, rd;
        logic       to;
        for (int k = 0; k <= 16; k++) begin
            drive_beat(mk(2, k), k == 0, wr, rd, to);
            checks++;
            if (to !== 1'b0) begin
                errors++;
                $display("FAIL bp_timeout beat %0d: s_ready stuck 0", k);
            end
        end
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = mk(2, 17);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (s_ready !== 1'b0 || buf_wr_en !== 3'b000 || buf_rd_en !== 3'b000) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: ready=%b wr=%b rd=%b expected 0/000/000", i, s_ready, buf_wr_en, buf_rd_en);
            end
            @(posedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_cur !== mk(2, 16) || m_col !== 2'd0 || m_row_base !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b cur=%h col=%0d base=%0d expected 1/%h/0/2",
                         i, m_valid, m_cur, m_col, m_row_base, mk(2, 16));
            end
        end
        m_ready = 1'b1;
        for (int k = 17; k < 256; k++) begin
            drive_beat(mk(2, k), 1'b0, wr, rd, to);
            checks++;
            if (to !== 1'b0 || m_cur !== mk(2, k) || m_col !== 2'(k % 4)) begin
                errors++;
                $display("FAIL bp_resume beat %0d: to=%b cur=%h col=%0d expected 0/%h/%0d", k, to, m_cur, m_col, mk(2, k), k % 4);
            end
            if (k == 17) begin
                checks++;
                if (wr !== 3'b010) begin
                    errors++;
                    $display("FAIL bp_first_wr: wr=%b expected 010", wr);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: frame_done=%b expected 1", frame_done);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("test_backpressure done");
    endtask

    task automatic test_sof();
        logic [2:0] wr, rd;
        logic       to;
        for (int k = 0; k < 22; k++)
            drive_beat(mk(3, k), k == 0, wr, rd, to);
        checks++;
        if (m_valid !== 1'b1 || sof_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_pre: valid=%b err=%b expected 1/0", m_valid, sof_err);
        end
        drive_beat(mk(3, 22), 1'b1, wr, rd, to);
        checks++;
        if (to !== 1'b0 || wr !== 3'b001 || sof_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL sof_mis: to=%b wr=%b err=%b valid=%b expected 0/001/1/0", to, wr, sof_err, m_valid);
        end
        for (int j = 1; j < 256; j++) begin
            int row = j / 4;
            drive_beat(mk(3, 100 + j), 1'b0, wr, rd, to);
            checks++;
            if (to !== 1'b0 || wr !== (3'b001 << (row % 3)) || m_valid !== (row >= 2) || sof_err !== 1'b1) begin
                errors++;
                $display("FAIL sof_after beat %0d: to=%b wr=%b valid=%b err=%b expected 0/%b/%b/1",
                         j, to, wr, m_valid, sof_err, 3'b001 << (row % 3), row >= 2);
            end
            if (j == 8) begin
                checks++;
                if (m_row_base !== 2'd0 || m_col !== 2'd0 || m_cur !== mk(3, 108)) begin
                    errors++;
                    $display("FAIL sof_first_win: base=%0d col=%0d cur=%h expected 0/0/%h", m_row_base, m_col, m_cur, mk(3, 108));
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL sof_done: frame_done=%b expected 1", frame_done);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("test_sof done");
    endtask

    task automatic test_reset_mid();
        logic [2:0] wr, rd;
        logic       to;
        int         vcnt = 0;
        for (int k = 0; k <= 40; k++)
            drive_beat(mk(4, k), k == 0, wr, rd, to);
        aresetn = 1'b0;
        s_valid = 1'b1;
        s_data  = mk(4, 41);
        #1;
        checks++;
        if (buf_wr_en !== 3'b000 || buf_rd_en !== 3'b000 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_en: wr=%b rd=%b ready=%b expected 000/000/0", buf_wr_en, buf_rd_en, s_ready);
        end
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        checks++;
        if (m_valid !== 1'b0 || m_cur !== 128'b0 || sof_err !== 1'b0 || m_col !== 2'd0 || m_row_base !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_state: valid=%b cur=%h err=%b col=%0d base=%0d expected 0", m_valid, m_cur, sof_err, m_col, m_row_base);
        end
        for (int k = 0; k < 256; k++) begin
            int row = k / 4;
            int col = k % 4;
            drive_beat(mk(5, k), k == 0, wr, rd, to);
            checks++;
            if (to !== 1'b0 || wr !== (3'b001 << (row % 3)) || m_valid !== (row >= 2)) begin
                errors++;
                $display("FAIL rstmid_beat %0d: to=%b wr=%b valid=%b expected 0/%b/%b", k, to, wr, m_valid, 3'b001 << (row % 3), row >= 2);
            end
            if (row >= 2) begin
                vcnt++;
                checks++;
                if ({m_row_base, m_col} !== {2'((row % 3 + 1) % 3), 2'(col)} || m_cur !== mk(5, k)) begin
                    errors++;
                    $display("FAIL rstmid_window beat %0d: base=%0d col=%0d cur=%h expected %0d/%0d/%h",
                             k, m_row_base, m_col, m_cur, (row % 3 + 1) % 3, col, mk(5, k));
                end
            end
        end
        checks++;
        if (vcnt != 248 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_frame: windows=%0d done=%b expected 248/1", vcnt, frame_done);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("test_reset_mid done");
    endtask

`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
    task automatic test_stall_cnt();
        logic [2:0] wr, rd;
        logic       to;
        for (int k = 0; k <= 8; k++)
            drive_beat(mk(6, k), k == 0, wr, rd, to);
        m_ready = 1'b0;
        s_data  = mk(6, 9);
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 32'd7) begin
            errors++;
            $display("FAIL stall_count: stall_cnt=%0d expected 7", stall_cnt);
        end
        m_ready = 1'b1;
        for (int k = 9; k < 256; k++)
            drive_beat(mk(6, k), 1'b0, wr, rd, to);
        checks++;
        if (stall_cnt !== 32'd7) begin
            errors++;
            $display("FAIL stall_hold: stall_cnt=%0d expected 7", stall_cnt);
        end
        drive_beat(mk(7, 0), 1'b1, wr, rd, to);
        checks++;
        if (to !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_clear: to=%b stall_cnt=%0d expected 0/0", to, stall_cnt);
        end
        s_valid = 1'b0;
        $display("test_stall_cnt done");
    endtask
`endif

    initial begin
        aresetn = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_sof();
        test_reset_mid();
`ifdef ROW_BUFF_SCHED_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
